// File: rtl/sbox_mask_in_stage.sv
// Masking feeder for the GF(2^8) inverter: draws fresh input/output masks from an LFSR,
// maps masked data and mask into tower coordinates, and queues them in a 2-entry buffer.

module sbox_basis_row #(
    parameter logic [7:0] ROW = 8'h01
) (
    input  logic [7:0] x,
    output logic       y
);
    assign y = ^(ROW & x);
endmodule

module sbox_mask_in_stage #(
    parameter logic [63:0] BASIS = 64'h8040201008040201,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        mask_en,
    input  logic        seed_load,
    input  logic [15:0] seed_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  a_out,
    output logic [7:0]  m_out,
    output logic [7:0]  n_out
);
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] m;
        logic [7:0] n;
    } entry_t;

    function automatic logic [15:0] lfsr_adv16(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int k = 0; k < 16; k++)
            t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        return t;
    endfunction

    logic [15:0] lfsr;
    logic [7:0]  m_raw, n_raw, masked, a_map, m_map;
    logic        accept, pop;
    logic [1:0]  count, count_nxt;
    logic        wr_ptr, rd_ptr;
    entry_t      mem [2];
    entry_t      head;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign m_raw  = mask_en ? lfsr[15:8] : 8'h00;
    assign n_raw  = mask_en ? lfsr[7:0]  : 8'h00;
    // Mask is applied before the linear map so the raw byte never reaches a register.
    assign masked = in_data ^ m_raw;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_row
            sbox_basis_row #(.ROW(BASIS[8*i +: 8])) u_a (.x(masked), .y(a_map[i]));
            sbox_basis_row #(.ROW(BASIS[8*i +: 8])) u_m (.x(m_raw),  .y(m_map[i]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else if (seed_load)
            lfsr <= (seed_val == 16'h0000) ? SEED : seed_val;
        else if (accept)
            lfsr <= lfsr_adv16(lfsr);
    end

    always_comb begin
        count_nxt = count;
        if (accept && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !accept)
            count_nxt = count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= '{a: a_map, m: m_map, n: n_raw};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != 2'd0);
    assign a_out     = head.a;
    assign m_out     = head.m;
    assign n_out     = head.n;
endmodule

// File: tb/tb_sbox_mask_in_stage.sv
// Directed bench for sbox_mask_in_stage: identity-basis and nibble-swap-basis instances
// share stimulus and run in lockstep.

module tb_sbox_mask_in_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, mask_en, seed_load, out_ready;
    logic [7:0]  in_data;
    logic [15:0] seed_val;
    logic        in_ready, out_valid, s_in_ready, s_out_valid;
    logic [7:0]  a_out, m_out, n_out, s_a_out, s_m_out, s_n_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sbox_mask_in_stage u_id (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mask_en(mask_en), .seed_load(seed_load), .seed_val(seed_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .m_out(m_out), .n_out(n_out)
    );

    sbox_mask_in_stage #(.BASIS(64'h0804020180402010)) u_sw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .mask_en(mask_en), .seed_load(seed_load), .seed_val(seed_val),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .a_out(s_a_out), .m_out(s_m_out), .n_out(s_n_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] adv16(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int k = 0; k < 16; k++)
            t = {t[14:0], t[15] ^ t[13] ^ t[12] ^ t[10]};
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        out_ready = 1'b0;
    endtask

    logic [15:0] s1;
    logic [7:0]  d, got_q [3];
    int          n_got;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; mask_en = 1'b0;
        seed_load = 1'b0; seed_val = 16'h0000; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_a", a_out, 0);
        chk("rst_m", m_out, 0);
        chk("rst_n", n_out, 0);

        // Unmasked KAT on both bases
        push(8'h53);
        chk("kat_valid", out_valid, 1);
        chk("kat_a", a_out, 8'h53);
        chk("kat_m", m_out, 8'h00);
        chk("kat_n", n_out, 8'h00);
        chk("kat_swap_a", s_a_out, 8'h35);
        drain();
        chk("kat_drained", out_valid, 0);

        // Masked draw from the seed, then the advanced state with push+pop overlap
        rst = 1'b1; step(); rst = 1'b0;
        mask_en = 1'b1;
        push(8'h53);
        chk("mask_m", m_out, 8'hAC);
        chk("mask_n", n_out, 8'hE1);
        chk("mask_a", a_out, 8'hFF);
        s1 = adv16(16'hACE1);
        out_ready = 1'b1;
        push(8'h5A);
        chk("mask2_valid", out_valid, 1);
        chk("mask2_m", m_out, s1[15:8]);
        chk("mask2_n", n_out, s1[7:0]);
        chk("mask2_a", a_out, 8'h5A ^ s1[15:8]);
        drain();

        // Backpressure: third byte held upstream until space frees up
        push(8'h11);
        chk("bp_ready1", in_ready, 1);
        push(8'h22);
        chk("bp_ready2", in_ready, 0);
        in_valid = 1'b1; in_data = 8'h33;
        step();
        chk("bp_ready3", in_ready, 0);
        chk("bp_valid3", out_valid, 1);
        out_ready = 1'b1;
        n_got = 0;
        for (int cyc = 0; cyc < 10 && n_got < 3; cyc++) begin
            logic acc;
            acc = in_valid & in_ready;
            if (out_valid) begin
                got_q[n_got] = a_out ^ m_out;
                n_got++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_count", n_got, 3);
        chk("bp_out0", got_q[0], 8'h11);
        chk("bp_out1", got_q[1], 8'h22);
        chk("bp_out2", got_q[2], 8'h33);
        chk("bp_empty", out_valid, 0);

        // Masked nibble-swap invariant
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom_range(0, 255));
            push(d);
            chk("swap_inv", s_a_out ^ s_m_out, {d[3:0], d[7:4]});
            chk("id_inv", a_out ^ m_out, d);
        end
        drain();

        // Seed handling
        seed_load = 1'b1; seed_val = 16'h0000;
        step();
        seed_load = 1'b0;
        push(8'h00);
        chk("seed0_m", m_out, 8'hAC);
        chk("seed0_n", n_out, 8'hE1);
        drain();
        seed_load = 1'b1; seed_val = 16'h1234;
        push(8'h77);
        seed_load = 1'b0;
        chk("seedsame_m", m_out, s1[15:8]);
        chk("seedsame_n", n_out, s1[7:0]);
        out_ready = 1'b1;
        push(8'h88);
        chk("seednew_m", m_out, 8'h12);
        chk("seednew_n", n_out, 8'h34);
        chk("seednew_a", a_out, 8'h9A);
        drain();

        // Reset mid-stream with an attempted push during reset
        push(8'h01);
        push(8'h02);
        chk("mid_full", in_ready, 0);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_valid", out_valid, 0);
        chk("mid_ready", in_ready, 1);
        chk("mid_a", a_out, 0);
        push(8'h53);
        chk("mid_m", m_out, 8'hAC);
        chk("mid_n", n_out, 8'hE1);
        chk("mid_a2", a_out, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
